activation_unpack_stage: RTL
============================

Name: activation_unpack_stage

Overview:
- Read-side counterpart of the activation commit path. Consumes ACTIVATION_BANK_BIT_WIDTH-wide bank words from activation memory.
- Serves each request for k data words (0..9) as a DATA_AND_SM_ARRAY_WIDTH-word array: first word in the MSB slot, unused lower slots zero.
- A flush request discards the zero padding left in the current bank word, so the next segment starts on a bank-word boundary.

Parameters:
- DATA_BIT_WIDTH, 8, bits per data word.
- ACTIVATION_BANK_BIT_WIDTH, NVP_v1_constants::ACTIVATION_BANK_BIT_WIDTH, memory word width; must be a multiple of DATA_BIT_WIDTH.
- DATA_AND_SM_ARRAY_WIDTH (local), DATA_BIT_WIDTH+1, maximum words per request.
- N (local), ACTIVATION_BANK_BIT_WIDTH/DATA_BIT_WIDTH, words per bank word.
- BUF_WORDS (local), N+DATA_AND_SM_ARRAY_WIDTH-1, buffer capacity in words.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_mem_data  in  ACTIVATION_BANK_BIT_WIDTH  bank word read from memory; first word in the MSB slot.
- i_mem_valid  in  1  i_mem_data valid.
- o_mem_ready  out  1  buffer can accept a full bank word.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request accepted when valid & ready.
- i_req_pop_count  in  $clog2(DATA_AND_SM_ARRAY_WIDTH)  words requested (k).
- i_req_flush  in  1  after serving, drop rest of current bank word.
- o_output_array  out  DATA_AND_SM_ARRAY_WIDTH*DATA_BIT_WIDTH  served words, MSB-aligned, zero-filled.
- o_output_valid  out  1  one-cycle pulse per served request.
- o_output_last  out  1  qualifies o_output_valid; served request had flush set.

Behaviour:
- Reset values: o_mem_ready=0, o_req_ready=1, o_output_array=0, o_output_valid=0, o_output_last=0. Internally: avail=0, bank_pos=0, state=IDLE, buffer cleared.
- Reset asserted mid-operation: everything returns to the reset values on the next edge. Pending request and buffered words are lost. A bank word presented during reset is not accepted.
- Buffer:
  - Shift register of BUF_WORDS words, head word in the MSB slot.
  - avail = number of valid words.
  - bank_pos (0..N-1) = index of the head word within its original bank word.
- Load:
  - o_mem_ready is combinational: (avail <= DATA_AND_SM_ARRAY_WIDTH-1) && !reset.
  - On i_mem_valid & o_mem_ready, the N words are appended directly behind the last valid word, and avail increases by N.
  - Loading is independent of request state (prefetch).
- FSM states:
  - IDLE: o_req_ready=1. On accept, latch k (values > DATA_AND_SM_ARRAY_WIDTH clamp to DATA_AND_SM_ARRAY_WIDTH) and the flush bit; go to SERVE with o_req_ready=0.
  - SERVE: wait until registered avail >= k. Then in one cycle:
    - register the top k words into o_output_array (MSB-aligned, lower slots 0);
    - pulse o_output_valid with o_output_last=flush;
    - shift the buffer left by k; avail -= k; bank_pos = (bank_pos+k) mod N;
    - return to IDLE with o_req_ready=1.
  - Flush at serve: additionally drop d = (new bank_pos==0) ? 0 : N-new bank_pos words, set bank_pos=0, and avail -= k+d. All dropped words are already buffered, because bank words load atomically.
- k=0: served immediately, o_output_array=0, no words consumed. If flushed, only the padding is dropped.
- Latency: request accepted at edge T with data available gives o_output_valid high in cycle T+1→T+2. The next request can be accepted in that same cycle.
- Back-to-back requests: one served every 2 cycles.
- No output back-pressure; downstream must sample on the o_output_valid pulse.
- Simultaneous load and serve in one cycle:
  - serve uses the pre-edge contents;
  - the loaded word is appended after the shift/drop, at position avail-k-d;
  - the net avail update is applied atomically.
- Empty buffer with outstanding request: stay in SERVE indefinitely; o_req_ready stays 0.
- o_output_array holds its last value between pulses.

Test Plan (ACTIVATION_BANK_BIT_WIDTH=64, N=8):
- Reset then idle → o_mem_ready=1 after reset release, o_req_ready=1, o_output_valid=0; one load of words 0x01..0x08 leaves avail=8 and o_mem_ready=1.
- Load 0x01..0x08 and 0x09..0x10, then requests k=3,4,5 → outputs {01,02,03,0…}, {04..07,0…}, {08..0C,0…}; avail ends at 4.
- Load one bank word, request k=9 → no pulse until a second bank word loads; then one pulse with 9 words MSB-aligned, and avail=7 (16-9).
- Load two bank words, request k=3 with flush=1, then k=2 → first pulse has last=1; second pulse returns words 0x09,0x0A (words 4..8 dropped).
- Request k=0 flush=1 at bank_pos=0 → pulse with array=0, last=1, avail unchanged.
- Assert reset while in SERVE with avail=5 → next cycle o_req_ready=1, avail=0, no stale o_output_valid; a subsequent load/request returns fresh data only.

Source files
------------

// File: rtl/activation_unpack_stage.sv
// Read-side unpacker: buffers bank words from activation memory and serves
// MSB-aligned arrays of 0..9 data words, with optional flush to the next bank-word boundary.
package NVP_v1_constants;
    localparam int ACTIVATION_BANK_BIT_WIDTH = 64;
endpackage

module activation_unpack_stage #(
    parameter int DATA_BIT_WIDTH            = 8,
    parameter int ACTIVATION_BANK_BIT_WIDTH = NVP_v1_constants::ACTIVATION_BANK_BIT_WIDTH,
    localparam int DATA_AND_SM_ARRAY_WIDTH  = DATA_BIT_WIDTH + 1,
    localparam int KW                       = $clog2(DATA_AND_SM_ARRAY_WIDTH)
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic [ACTIVATION_BANK_BIT_WIDTH-1:0]              i_mem_data,
    input  logic                                              i_mem_valid,
    output logic                                              o_mem_ready,
    input  logic                                              i_req_valid,
    output logic                                              o_req_ready,
    input  logic [KW-1:0]                                     i_req_pop_count,
    input  logic                                              i_req_flush,
    output logic [DATA_AND_SM_ARRAY_WIDTH*DATA_BIT_WIDTH-1:0] o_output_array,
    output logic                                              o_output_valid,
    output logic                                              o_output_last
);
    localparam int N         = ACTIVATION_BANK_BIT_WIDTH / DATA_BIT_WIDTH;
    localparam int BUF_WORDS = N + DATA_AND_SM_ARRAY_WIDTH - 1;
    localparam int AW        = $clog2(BUF_WORDS + 1);
    localparam int IW        = $clog2(BUF_WORDS);
    localparam int PW        = (N > 1) ? $clog2(N) : 1;
    localparam int OW        = DATA_AND_SM_ARRAY_WIDTH * DATA_BIT_WIDTH;

    typedef logic [DATA_BIT_WIDTH-1:0] word_t;
    typedef enum logic {IDLE, SERVE} state_t;

    state_t        state_q, state_n;
    word_t         buf_q [BUF_WORDS];
    word_t         buf_n [BUF_WORDS];
    word_t         mem_words [N];
    logic [AW-1:0] avail_q, avail_n;
    logic [PW-1:0] pos_q, pos_n;
    logic [KW-1:0] k_q, k_n;
    logic          flush_q, flush_n;
    logic          serve, load;
    logic [OW-1:0] array_n;
    int            k_in, new_pos, drop, consume, base;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    // Next-state and datapath next values
    always_comb begin
        state_n = state_q;
        k_n     = k_q;
        flush_n = flush_q;
        serve   = 1'b0;
        drop    = 0;
        consume = 0;
        k_in    = (int'(i_req_pop_count) > DATA_AND_SM_ARRAY_WIDTH) ? DATA_AND_SM_ARRAY_WIDTH
                                                                     : int'(i_req_pop_count);
        new_pos = (int'(pos_q) + int'(k_q)) % N;
        load    = i_mem_valid && o_mem_ready;
        pos_n   = pos_q;

        case (state_q)
            IDLE: if (i_req_valid) begin
                k_n     = KW'(k_in);
                flush_n = i_req_flush;
                state_n = SERVE;
            end
            SERVE: if (int'(avail_q) >= int'(k_q)) begin
                serve   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (serve) begin
            // Padding is always fully buffered: bank words only ever arrive whole.
            drop    = (flush_q && new_pos != 0) ? N - new_pos : 0;
            consume = int'(k_q) + drop;
            pos_n   = flush_q ? '0 : PW'(new_pos);
        end

        for (int j = 0; j < N; j++)
            mem_words[j] = i_mem_data[ACTIVATION_BANK_BIT_WIDTH-1-j*DATA_BIT_WIDTH -: DATA_BIT_WIDTH];

        // Shift out consumed words first, then append the new bank word behind the survivors.
        base = int'(avail_q) - consume;
        for (int i = 0; i < BUF_WORDS; i++) begin
            if (i + consume < BUF_WORDS) buf_n[i] = buf_q[IW'(i + consume)];
            else                         buf_n[i] = '0;
            if (load && i >= base && i < base + N)
                buf_n[i] = mem_words[PW'(i - base)];
        end
        avail_n = AW'(int'(avail_q) - consume + (load ? N : 0));

        array_n = '0;
        for (int s = 0; s < DATA_AND_SM_ARRAY_WIDTH; s++)
            if (s < int'(k_q))
                array_n[(DATA_AND_SM_ARRAY_WIDTH-s)*DATA_BIT_WIDTH-1 -: DATA_BIT_WIDTH] = buf_q[s];
    end

    // Output decode
    always_comb begin
        o_req_ready = (state_q == IDLE);
        o_mem_ready = (int'(avail_q) <= DATA_AND_SM_ARRAY_WIDTH - 1) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the word buffer is small and must read back as zero after reset, so it is cleared here.
            for (int i = 0; i < BUF_WORDS; i++) buf_q[i] <= '0;
            avail_q        <= '0;
            pos_q          <= '0;
            k_q            <= '0;
            flush_q        <= 1'b0;
            o_output_array <= '0;
            o_output_valid <= 1'b0;
            o_output_last  <= 1'b0;
        end else begin
            buf_q          <= buf_n;
            avail_q        <= avail_n;
            pos_q          <= pos_n;
            k_q            <= k_n;
            flush_q        <= flush_n;
            o_output_valid <= serve;
            o_output_last  <= serve && flush_q;
            if (serve) o_output_array <= array_n;
        end
    end
endmodule
